pht_update_scheduler: RTL and testbench

//  Sequences all writes into the gshare pattern history table (PHT), which has a single write port.

---
 rtl/pht_update_scheduler_pkg.sv | 36 +++
 rtl/pht_update_queue.sv | 59 +++++
 rtl/pht_update_scheduler.sv | 130 +++++++++++++
 tb/tb_pht_update_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// rtl/pht_update_scheduler_pkg.sv - shared PHT types, constants and counter arithmetic
package pht_update_scheduler_pkg;

    localparam int PHT_INDEX_WIDTH = 10;
    localparam int PHT_ENTRY_NUM   = 1 << PHT_INDEX_WIDTH;

    typedef logic [PHT_INDEX_WIDTH-1:0] PHT_IndexPath;
    typedef logic [1:0]                 PHT_CounterPath;

    // One resolved branch waiting to be folded into the table
    typedef struct packed {
        PHT_IndexPath   index;
        logic           taken;
        PHT_CounterPath oldCnt;
    } PhtUpdateEntry;

    // Weakly taken
    localparam PHT_CounterPath PHT_INIT_VALUE = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } sched_state_e;

    // Two-bit saturating counter step
    function automatic PHT_CounterPath sat_update(input PHT_CounterPath base, input logic taken);
        PHT_CounterPath result;
        if (taken) begin
            result = (base == 2'b11) ? 2'b11 : base + 2'b01;
        end else begin
            result = (base == 2'b00) ? 2'b00 : base - 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/pht_update_queue.sv
// rtl/pht_update_queue.sv - multi-push single-pop FIFO of pending PHT updates
module pht_update_queue
    import pht_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES-1:0]                push_valid,
    input  PhtUpdateEntry [LANES-1:0]       push_data,
    input  logic                            pop,
    output PhtUpdateEntry                   head,
    output logic [CNT_W-1:0]                count
);

    localparam int PTR_W = $clog2(DEPTH);

    PhtUpdateEntry      mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   slot [LANES];
    logic [CNT_W-1:0]   push_cnt;
    logic               pop_ok;

    // Compact valid lanes: each valid lane lands after all lower valid lanes
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wr_ptr + PTR_W'(push_cnt);
            if (push_valid[i]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Pointer/count bookkeeping and storage writes; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push_valid[i]) begin
                    mem[slot[i]] <= push_data[i];
                end
            end
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop_ok);
            count  <= count + push_cnt - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/pht_update_scheduler.sv
// rtl/pht_update_scheduler.sv - init sweep and single-port write sequencing for the gshare PHT
module pht_update_scheduler
    import pht_update_scheduler_pkg::*;
#(
    parameter int             QUEUE_DEPTH  = 8,
    parameter int             COMMIT_WIDTH = 2,
    parameter PHT_CounterPath INIT_VALUE   = PHT_INIT_VALUE
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [COMMIT_WIDTH-1:0]                            updValid,
    input  logic [COMMIT_WIDTH-1:0][PHT_INDEX_WIDTH-1:0]       updIndex,
    input  logic [COMMIT_WIDTH-1:0]                            updTaken,
    input  logic [COMMIT_WIDTH-1:0][1:0]                       updOldCnt,
    output logic                                               updReady,
    output logic                                               phtWE,
    output logic [PHT_INDEX_WIDTH-1:0]                         phtWA,
    output logic [1:0]                                         phtWV,
    output logic                                               initBusy
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    sched_state_e                    state;
    sched_state_e                    next_state;
    PHT_IndexPath                    sweep_ptr;
    logic                            fwd_valid;
    PHT_IndexPath                    fwd_index;
    PHT_CounterPath                  fwd_value;

    PhtUpdateEntry [COMMIT_WIDTH-1:0] push_data;
    logic [COMMIT_WIDTH-1:0]          push_valid;
    PhtUpdateEntry                    head;
    logic [CNT_W-1:0]                 count;
    logic                             pop;
    PHT_CounterPath                   base;

    // Pack commit lanes into queue entries
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            push_data[i] = '{index: updIndex[i], taken: updTaken[i], oldCnt: updOldCnt[i]};
        end
    end

    // Lanes presented while not ready are dropped
    assign push_valid = updValid & {COMMIT_WIDTH{updReady}};

    pht_update_queue #(
        .DEPTH (QUEUE_DEPTH),
        .LANES (COMMIT_WIDTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // Back-to-back updates of one index build on the value just written
    assign base = (fwd_valid && (fwd_index == head.index)) ? fwd_value : head.oldCnt;

    // Next-state and write-port drive; reset cycle suppresses writes and acceptance
    always_comb begin
        next_state = state;
        updReady   = 1'b0;
        phtWE      = 1'b0;
        phtWA      = '0;
        phtWV      = '0;
        initBusy   = 1'b0;
        pop        = 1'b0;
        if (!rst) begin
            initBusy = 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    initBusy = 1'b1;
                    phtWE    = 1'b1;
                    phtWA    = sweep_ptr;
                    phtWV    = INIT_VALUE;
                    if (sweep_ptr == PHT_IndexPath'(PHT_ENTRY_NUM - 1)) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    updReady = (count <= CNT_W'(QUEUE_DEPTH - COMMIT_WIDTH));
                    if (count != '0) begin
                        pop   = 1'b1;
                        phtWE = 1'b1;
                        phtWA = head.index;
                        phtWV = sat_update(base, head.taken);
                    end
                end
                default: next_state = ST_INIT;
            endcase
        end
    end

    // State register and sweep pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == ST_INIT) begin
                sweep_ptr <= sweep_ptr + PHT_IndexPath'(1);
            end
        end
    end

    // Remember the last update write; sweep writes never forward
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_valid <= 1'b0;
            fwd_index <= '0;
            fwd_value <= '0;
        end else if ((state == ST_RUN) && phtWE) begin
            fwd_valid <= 1'b1;
            fwd_index <= phtWA;
            fwd_value <= phtWV;
        end
    end

    // Commit must not present updates while the scheduler is not ready
    assert property (@(posedge clk) disable iff (!rst) !((|updValid) && !updReady));

endmodule

// File: tb/tb_pht_update_scheduler.sv
// tb/tb_pht_update_scheduler.sv - scoreboard bench for pht_update_scheduler
module tb_pht_update_scheduler;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      updValid = '0;
    logic [1:0][9:0] updIndex = '0;
    logic [1:0]      updTaken = '0;
    logic [1:0][1:0] updOldCnt = '0;
    logic            updReady;
    logic            phtWE;
    logic [9:0]      phtWA;
    logic [1:0]      phtWV;
    logic            initBusy;

    int          errors = 0;
    int          checks = 0;
    logic [11:0] exp_q [$];
    logic [11:0] exp_e;
    bit          m_valid = 0;
    int          m_idx = 0;
    int          m_val = 0;
    int          writes_seen = 0;
    int          sweep_n = 0;
    int          sweep_bad = 0;
    bit          saw_not_ready = 0;
    int          snapshot = 0;

    pht_update_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .updValid  (updValid),
        .updIndex  (updIndex),
        .updTaken  (updTaken),
        .updOldCnt (updOldCnt),
        .updReady  (updReady),
        .phtWE     (phtWE),
        .phtWA     (phtWA),
        .phtWV     (phtWV),
        .initBusy  (initBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int b, input bit t);
        if (t) return (b >= 3) ? 3 : b + 1;
        return (b <= 0) ? 0 : b - 1;
    endfunction

    task automatic model_push(input int idx, input bit t, input int o);
        int b;
        int v;
        b = (m_valid && m_idx == idx) ? m_val : o;
        v = sat(b, t);
        exp_q.push_back({idx[9:0], v[1:0]});
        m_valid = 1;
        m_idx   = idx;
        m_val   = v;
    endtask

    task automatic push2(input bit v0, input int i0, input bit t0, input int o0,
                         input bit v1, input int i1, input bit t1, input int o1);
        int guard = 0;
        updValid = '0;
        while (!updReady && guard < 20) begin
            saw_not_ready = 1;
            @(posedge clk); #1;
            guard++;
        end
        if (!updReady) begin
            check("ready_timeout", 0, 1);
            return;
        end
        updValid     = {v1, v0};
        updIndex[0]  = i0[9:0];
        updTaken[0]  = t0;
        updOldCnt[0] = o0[1:0];
        updIndex[1]  = i1[9:0];
        updTaken[1]  = t1;
        updOldCnt[1] = o1[1:0];
        if (v0) model_push(i0, t0, o0);
        if (v1) model_push(i1, t1, o1);
        @(posedge clk); #1;
        updValid = '0;
    endtask

    task automatic wait_run();
        int g = 0;
        while (initBusy && g < 1100) begin
            @(posedge clk); #1;
            g++;
        end
        check("init_done", initBusy, 0);
        check("init_len", sweep_n, 1024);
        check("init_bad", sweep_bad, 0);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check(tag, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Observe the write port away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            sweep_n   = 0;
            sweep_bad = 0;
        end else if (initBusy) begin
            if (!(phtWE && phtWA == sweep_n[9:0] && phtWV == 2'b10)) sweep_bad++;
            sweep_n++;
        end else if (phtWE) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_idx", int'(phtWA), int'(exp_e[11:2]));
                check("wr_val", int'(phtWV), int'(exp_e[1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_we", phtWE, 0);
        check("rst_ready", updReady, 0);
        check("rst_busy", initBusy, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wait_run();
        check("run_ready", updReady, 1);

        push2(1, 5, 1, 3, 0, 0, 0, 0);
        drain("drain_sat_high");

        push2(1, 7, 1, 1, 1, 7, 1, 1);
        drain("drain_fwd");

        saw_not_ready = 0;
        for (int k = 0; k < 8; k++) begin
            push2(1, 100 + 2 * k, k[0], k % 4, 1, 101 + 2 * k, !k[0], (k + 1) % 4);
        end
        check("ready_fell", saw_not_ready, 1);
        drain("drain_burst");
        check("ready_after_drain", updReady, 1);

        push2(1, 1023, 0, 0, 0, 0, 0, 0);
        drain("drain_sat_low");

        for (int k = 0; k < 14; k++) begin
            push2((k % 3) != 2, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
        end
        drain("drain_wrap");

        for (int k = 0; k < 4; k++) begin
            push2(1, 200 + 2 * k, 1, 1, 1, 201 + 2 * k, 0, 2);
        end
        rst = 1'b0;
        exp_q.delete();
        m_valid = 0;
        @(negedge clk);
        check("mid_rst_we", phtWE, 0);
        check("mid_rst_busy", initBusy, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        snapshot = writes_seen;
        wait_run();
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_quiet", writes_seen, snapshot);

        push2(1, 9, 0, 2, 0, 0, 0, 0);
        drain("drain_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
